// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings for the multiply/divide sequencer
//
// Contents:
//   OP_*     operation encodings presented on op
//   state_t  sequencer state enum
//   ALU_*    adder control codes driven on the shared adder
//   DZ_QUOT  quotient returned for a divide by zero

package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0011;

    localparam logic [31:0] DZ_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREP   = 3'd1,
        ST_CALC   = 3'd2,
        ST_FIX_LO = 3'd3,
        ST_FIX_HI = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/mdu_seq_ctrl_adder.sv
// rtl/mdu_seq_ctrl_adder.sv - 32-bit carry-lookahead adder shared by the sequencer
//
// Ports:
//   i_a, i_b      32-bit operands (callers invert B themselves for subtraction)
//   i_cin         carry in
//   i_alu_ctl     operation code; any non-zero code enables overflow reporting
//   o_sum         i_a + i_b + i_cin (low 32 bits)
//   o_cout        carry out of bit 31
//   o_overflow    signed overflow of the addition
//   o_zero        o_sum is all zeros

module mdu_seq_ctrl_adder (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    input  logic [3:0]  i_alu_ctl,
    output logic [31:0] o_sum,
    output logic        o_cout,
    output logic        o_overflow,
    output logic        o_zero
);

    logic [31:0] w_g;
    logic [31:0] w_p;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // 4-bit lookahead groups; group carries chain between groups.
    always_comb begin : cla
        logic [32:0] c;
        int          b;
        c    = '0;
        c[0] = i_cin;
        for (int k = 0; k < 8; k++) begin
            b = k * 4;
            c[b+1] = w_g[b] | (w_p[b] & c[b]);
            c[b+2] = w_g[b+1] | (w_p[b+1] & w_g[b]) | (w_p[b+1] & w_p[b] & c[b]);
            c[b+3] = w_g[b+2] | (w_p[b+2] & w_g[b+1]) | (w_p[b+2] & w_p[b+1] & w_g[b])
                   | (w_p[b+2] & w_p[b+1] & w_p[b] & c[b]);
            c[b+4] = w_g[b+3] | (w_p[b+3] & w_g[b+2]) | (w_p[b+3] & w_p[b+2] & w_g[b+1])
                   | (w_p[b+3] & w_p[b+2] & w_p[b+1] & w_g[b])
                   | (w_p[b+3] & w_p[b+2] & w_p[b+1] & w_p[b] & c[b]);
        end
        o_sum      = w_p ^ c[31:0];
        o_cout     = c[32];
        o_overflow = (|i_alu_ctl) & (i_a[31] == i_b[31]) & (o_sum[31] != i_a[31]);
        o_zero     = (o_sum == 32'd0);
    end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// rtl/mdu_seq_ctrl.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer on one shared adder
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   start         launch request, sampled only while idle
//   op            00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a, src_b  multiplicand/dividend, multiplier/divisor
//   busy          high while an op is in flight (cleared in the done cycle)
//   done          one-cycle result-valid pulse
//   div_by_zero   divide with zero divisor, valid with done
//   hi, lo        MUL: product[63:32]/[31:0]; DIV: remainder/quotient

module mdu_seq_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             r_state;
    logic               r_is_div;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_fix_c;
    logic               r_busy;
    logic               r_done;
    logic               r_dz;

    logic [WIDTH-1:0]   w_add_a;
    logic [WIDTH-1:0]   w_add_b;
    logic               w_add_cin;
    logic [3:0]         w_add_ctl;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_add_ovf;
    logic               w_add_zero;
    logic               w_unused_flags;

    logic [WIDTH-1:0]   w_lo_src;
    logic               w_lo_neg;
    logic [WIDTH-1:0]   w_hi_sh;
    logic               w_sign_diff;
    logic               w_fix_hi;
    logic [WIDTH-1:0]   w_mul_s;
    logic               w_mul_c;

    // The operand that seeds lo (multiplier for MUL, dividend for DIV) is made
    // positive in PREP. The other operand stays as latched; when it is negative
    // its magnitude is folded into the CALC adder inputs instead:
    //   MUL: hi + |m| = hi + ~m + 1       DIV: hi - |d| = hi + d
    assign w_lo_src    = r_is_div ? r_a : r_b;
    assign w_lo_neg    = r_is_div ? r_sign_a : r_sign_b;
    assign w_hi_sh     = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    assign w_sign_diff = r_sign_a ^ r_sign_b;
    assign w_fix_hi    = r_is_div ? r_sign_a : w_sign_diff;
    assign w_mul_s     = r_lo[0] ? w_sum : r_hi;
    assign w_mul_c     = r_lo[0] & w_cout;

    assign w_unused_flags = w_add_ovf | w_add_zero;

    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        w_add_ctl = 4'b0000;
        case (r_state)
            ST_PREP: begin
                if (w_lo_neg) begin
                    w_add_b   = ~w_lo_src;
                    w_add_cin = 1'b1;
                    w_add_ctl = ALU_ADD;
                end
            end
            ST_CALC: begin
                if (r_is_div) begin
                    w_add_a   = w_hi_sh;
                    w_add_b   = r_sign_b ? r_b : ~r_b;
                    w_add_cin = ~r_sign_b;
                    w_add_ctl = ALU_SUB;
                end else if (r_lo[0]) begin
                    w_add_a   = r_hi;
                    w_add_b   = r_sign_a ? ~r_a : r_a;
                    w_add_cin = r_sign_a;
                    w_add_ctl = ALU_ADD;
                end
            end
            ST_FIX_LO: begin
                if (w_sign_diff) begin
                    w_add_b   = ~r_lo;
                    w_add_cin = 1'b1;
                    w_add_ctl = ALU_ADD;
                end
            end
            ST_FIX_HI: begin
                if (w_fix_hi) begin
                    w_add_b   = ~r_hi;
                    w_add_cin = r_is_div ? 1'b1 : r_fix_c;
                    w_add_ctl = ALU_ADD;
                end
            end
            default: ;
        endcase
    end

    mdu_seq_ctrl_adder u_adder (
        .i_a        (w_add_a),
        .i_b        (w_add_b),
        .i_cin      (w_add_cin),
        .i_alu_ctl  (w_add_ctl),
        .o_sum      (w_sum),
        .o_cout     (w_cout),
        .o_overflow (w_add_ovf),
        .o_zero     (w_add_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_is_div <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_fix_c  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_is_div <= op[1];
                        r_a      <= src_a;
                        r_b      <= src_b;
                        r_sign_a <= ~op[0] & src_a[WIDTH-1];
                        r_sign_b <= ~op[0] & src_b[WIDTH-1];
                        r_dz     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    r_cnt <= '0;
                    if (r_is_div && (r_b == '0)) begin
                        r_hi    <= r_a;
                        r_lo    <= DZ_QUOT;
                        r_dz    <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_hi    <= '0;
                        r_lo    <= w_lo_neg ? w_sum : w_lo_src;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (r_is_div) begin
                        // Restoring step: keep the trial remainder when the
                        // shifted partial remainder (33 bits incl. msb) >= divisor.
                        if (r_hi[WIDTH-1] | w_cout) begin
                            r_hi <= w_sum;
                            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_hi <= w_hi_sh;
                            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_hi <= {w_mul_c, w_mul_s[WIDTH-1:1]};
                        r_lo <= {w_mul_s[0], r_lo[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= ST_FIX_LO;
                    end
                end
                ST_FIX_LO: begin
                    if (w_sign_diff) begin
                        r_lo    <= w_sum;
                        r_fix_c <= w_cout;
                    end
                    r_state <= ST_FIX_HI;
                end
                ST_FIX_HI: begin
                    if (w_fix_hi) begin
                        r_hi <= w_sum;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
